vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with delayed sync, blank and line/frame pulses
// Define VGA_FRAME_CNT_EN to implement the completed-frame counter; otherwise frame_cnt is 0.
module vga_timing_gen #(
  parameter int HACTIVE   = 640,
  parameter int HFP       = 16,
  parameter int HSYN      = 96,
  parameter int HBP       = 48,
  parameter int VACTIVE   = 480,
  parameter int VFP       = 11,
  parameter int VSYN      = 2,
  parameter int VBP       = 32,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int PIPE_DLY  = 2,
  parameter int CW        = 10,
  parameter int FCW       = 8
) (
  input  logic           vgaclk,
  input  logic           reset,
  input  logic           pix_en,
  input  logic           restart,
  output logic           hsync,
  output logic           vsync,
  output logic           sync_b,
  output logic           blank_b,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  localparam int HTOTAL = HACTIVE + HFP + HSYN + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYN + VBP;

  localparam logic [CW-1:0] HLAST  = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] VLAST  = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] HACT   = CW'(HACTIVE);
  localparam logic [CW-1:0] VACT   = CW'(VACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(HACTIVE + HFP);
  localparam logic [CW-1:0] HS_END = CW'(HACTIVE + HFP + HSYN);
  localparam logic [CW-1:0] VS_BEG = CW'(VACTIVE + VFP);
  localparam logic [CW-1:0] VS_END = CW'(VACTIVE + VFP + VSYN);
  localparam logic          HPOL   = (HSYNC_POL != 0);
  localparam logic          VPOL   = (VSYNC_POL != 0);

  logic       x_last;
  logic       y_last;
  logic [4:0] cur;
  logic [4:0] dly;

  assign x_last = (x == HLAST);
  assign y_last = (y == VLAST);

  // restart overrides wrap but only on an enabled pixel
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (pix_en) begin
      if (restart) begin
        x <= '0;
        y <= '0;
      end else if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + CW'(1);
      end else begin
        x <= x + CW'(1);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FCW-1:0] fcnt;

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      fcnt <= '0;
    end else if (pix_en && !restart && x_last && y_last) begin
      fcnt <= fcnt + FCW'(1);
    end
  end

  assign frame_cnt = fcnt;
`else
  assign frame_cnt = '0;
`endif

  // sync bits are carried as "asserted" flags so an all-zero stage is idle
  assign cur = {(x >= HS_BEG) && (x < HS_END),
                (y >= VS_BEG) && (y < VS_END),
                (x < HACT) && (y < VACT),
                (x == '0),
                (x == '0) && (y == '0)};

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign dly = cur;
    end else begin : g_dly
      logic [4:0] stg [PIPE_DLY];

      always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DLY; i++) stg[i] <= '0;
        end else if (pix_en) begin
          stg[0] <= cur;
          for (int i = 1; i < PIPE_DLY; i++) stg[i] <= stg[i-1];
        end
      end

      assign dly = stg[PIPE_DLY-1];
    end
  endgenerate

  assign hsync       = HPOL ? dly[4] : ~dly[4];
  assign vsync       = VPOL ? dly[3] : ~dly[3];
  assign blank_b     = dly[2];
  assign line_start  = dly[1];
  assign frame_start = dly[0];
  assign sync_b      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HPOL = 1, VPOL = 0, DLY = 2, CW = 10, FCW = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct {
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic           hs;
    logic           vs;
    logic           bl;
    logic           ls;
    logic           fs;
    logic [FCW-1:0] fc;
  } exp_t;

  logic           vgaclk = 1'b0;
  logic           reset;
  logic           pix_en;
  logic           restart;
  logic           hsync, vsync, sync_b, blank_b, line_start, frame_start;
  logic [CW-1:0]  x, y;
  logic [FCW-1:0] frame_cnt;

  vga_timing_gen #(
    .HACTIVE(HA), .HFP(HF), .HSYN(HS), .HBP(HB),
    .VACTIVE(VA), .VFP(VF), .VSYN(VS), .VBP(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .PIPE_DLY(DLY), .CW(CW), .FCW(FCW)
  ) dut (
    .vgaclk(vgaclk), .reset(reset), .pix_en(pix_en), .restart(restart),
    .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  always #5 vgaclk = ~vgaclk;

  int         tests = 0;
  int         fails = 0;
  bit         started = 0;
  int         pos;
  int         frames;
  logic [4:0] hist[$];
  exp_t       sb[$];

  // position within the frame is a single linear pixel index
  function automatic logic [4:0] cur_of(int p);
    int cx = p % HT;
    int cy = p / HT;
    return {(cx >= HA + HF) && (cx < HA + HF + HS),
            (cy >= VA + VF) && (cy < VA + VF + VS),
            (cx < HA) && (cy < VA),
            cx == 0,
            p == 0};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    pos = 0;
    frames = 0;
    hist.delete();
    for (int i = 0; i < DLY; i++) hist.push_back(5'b0);
  endtask

  task automatic model_edge(bit pe, bit rs);
    if (pe) begin
      if (DLY > 0) begin
        hist.push_back(cur_of(pos));
        void'(hist.pop_front());
      end
      if (rs) pos = 0;
      else begin
        pos++;
        if (pos == FRAME) begin
          pos = 0;
          frames++;
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    logic [4:0] d;
    d = (DLY == 0) ? cur_of(pos) : hist[0];
    e.x  = CW'(pos % HT);
    e.y  = CW'(pos / HT);
    e.hs = d[4] ? HPOL[0] : !HPOL[0];
    e.vs = d[3] ? VPOL[0] : !VPOL[0];
    e.bl = d[2];
    e.ls = d[1];
    e.fs = d[0];
`ifdef VGA_FRAME_CNT_EN
    e.fc = FCW'(frames % (1 << FCW));
`else
    e.fc = '0;
`endif
    sb.push_back(e);
  endtask

  task automatic drive(bit pe, bit rs);
    @(negedge vgaclk);
    reset   = 1'b0;
    pix_en  = pe;
    restart = rs;
    model_edge(pe, rs);
    push_expected();
    started = 1;
  endtask

  task automatic check_idle(string tag);
    check({tag, "_xy"}, {x, y}, '0);
    check({tag, "_sync"}, {hsync, vsync}, {!HPOL[0], !VPOL[0]});
    check({tag, "_blank_pulses"}, {blank_b, line_start, frame_start}, 3'b000);
    check({tag, "_frame_cnt"}, frame_cnt, '0);
  endtask

  // reset between edges, deep inside the vsync and hsync regions
  task automatic do_reset();
    @(negedge vgaclk);
    #2 reset = 1'b1;
    #1 check_idle("async_reset");
    model_reset();
    push_expected();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge vgaclk);
      #1;
      if (started) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("xy", {x, y}, {e.x, e.y});
          check("sync_blank_pulses", {hsync, vsync, blank_b, line_start, frame_start, sync_b},
                {e.hs, e.vs, e.bl, e.ls, e.fs, 1'b0});
          check("frame_cnt", frame_cnt, e.fc);
        end
      end
    end
  end

  initial begin : driver
    reset   = 1'b1;
    pix_en  = 1'b0;
    restart = 1'b0;
    model_reset();
    #6 check_idle("reset_state");

    repeat (4 * FRAME + 40) drive(1'b1, 1'b0);

    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);

    while (pos != 3 * HT + 5) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    repeat (HT + 3) drive(1'b1, 1'b0);

    while (pos != (VA + VF) * HT + HA + HF + 1) drive(1'b1, 1'b0);
    do_reset();
    repeat (DLY + 3) drive(1'b1, 1'b0);

    for (int i = 0; i < 2 * FRAME; i++) drive(i % 2 == 0, 1'b0);

    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1) != 0, $urandom_range(0, 63) == 0);

    @(posedge vgaclk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
